oled_bus_rx: RTL and testbench

//   Responder end of the 6800-style OLED parallel bus (cs/e/rw/dc/data). Captures every write

---
 rtl/oled_bus_rx.sv | 217 +++++++++++++++++++++
 tb/tb_oled_bus_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_bus_rx.sv
// ============================================================================
// oled_bus_rx
//   Receiving end of a 6800-style OLED parallel bus (cs/e/rw/dc/data).
//   Every write cycle is captured on the falling edge of e. It is tagged as a
//   command (dc=0) or a data byte (dc=1) and queued behind a valid/ready port.
//   The block also checks command/parameter framing. It reports dropped bytes
//   and framing violations through sticky flags, and keeps saturating byte
//   counters.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   oled_cs             chip select, active-low
//   oled_e              enable strobe; a write latches on its falling edge
//   oled_rw             1 = read cycle (unsupported), 0 = write cycle
//   oled_dc             0 = command byte, 1 = data/parameter byte
//   oled_din[7:0]       bus data
//   rx_valid/rx_ready   FIFO head handshake; a pop occurs when both are high
//   rx_dc, rx_data      tag and byte of the FIFO head
//   frame_done          1-cycle pulse when cs deasserts after an accepted write
//   overflow            sticky: a write was dropped because the FIFO was full
//   proto_err           sticky: a read cycle, or data before any command
//   err_clr             synchronous clear of overflow and proto_err
//   cmd_count           saturating count of captured command bytes
//   data_count          saturating count of captured data bytes
// ============================================================================
module oled_bus_rx #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             oled_cs,
   input  logic             oled_e,
   input  logic             oled_rw,
   input  logic             oled_dc,
   input  logic [7:0]       oled_din,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             rx_dc,
   output logic [7:0]       rx_data,
   output logic             frame_done,
   output logic             overflow,
   output logic             proto_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] cmd_count,
   output logic [CNT_W-1:0] data_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [1:0] {
      ST_DESEL    = 2'd0,
      ST_WAIT_CMD = 2'd1,
      ST_IN_CMD   = 2'd2
   } state_t;

   // Two-stage bus sampling. The cs of stage 2 is never consulted, so it is not kept.
   logic       q1_cs_q, q1_e_q, q1_rw_q, q1_dc_q;
   logic [7:0] q1_din_q;
   logic       q2_e_q, q2_rw_q, q2_dc_q;
   logic [7:0] q2_din_q;

   // FIFO storage and pointers. The extra pointer MSB separates full from empty.
   logic [8:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;

   logic             rx_valid_q, rx_valid_d;
   logic             rx_dc_q, rx_dc_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             frame_done_q, frame_done_d;
   logic             overflow_q, overflow_d;
   logic             proto_err_q, proto_err_d;
   logic [CNT_W-1:0] cmd_count_q, cmd_count_d;
   logic [CNT_W-1:0] data_count_q, data_count_d;
   state_t           state_q, state_d;
   logic             wrote_q, wrote_d;

   logic strobe_c, wr_stb_c, rd_stb_c;
   logic full_c, pop_c, push_c, drop_c;
   logic fsm_err_c;

   // Falling e: high in the older sample, low in the newer one, with cs low.
   assign strobe_c = q2_e_q & ~q1_e_q & ~q1_cs_q;
   assign wr_stb_c = strobe_c & ~q2_rw_q;
   assign rd_stb_c = strobe_c &  q2_rw_q;

   assign full_c = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_c  = rx_valid_q & rx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
   assign push_c = wr_stb_c & (~full_c | pop_c);
   assign drop_c = wr_stb_c & full_c & ~pop_c;

   // FIFO pointers and the registered head view.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rx_valid_d = 1'b0;
      rx_dc_d    = rx_dc_q;
      rx_data_d  = rx_data_q;
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_ptr_d != rd_ptr_d) begin
         rx_valid_d = 1'b1;
         // The new head is the entry being written this cycle: take it from the bus sample.
         if (push_c && (rd_ptr_d == wr_ptr_q)) begin
            rx_dc_d   = q2_dc_q;
            rx_data_d = q2_din_q;
         end else begin
            {rx_dc_d, rx_data_d} = fifo_mem[rd_ptr_d[AW-1:0]];
         end
      end
   end

   // Command/parameter framing tracker.
   always_comb begin
      state_d      = state_q;
      wrote_d      = wrote_q;
      frame_done_d = 1'b0;
      fsm_err_c    = 1'b0;
      if (q1_cs_q) begin
         frame_done_d = (state_q != ST_DESEL) && wrote_q;
         state_d      = ST_DESEL;
         wrote_d      = 1'b0;
      end else begin
         if (state_q == ST_DESEL) begin
            state_d = ST_WAIT_CMD;
            wrote_d = 1'b0;
         end
         if (push_c) begin
            wrote_d = 1'b1;
            if (!q2_dc_q) begin
               state_d = ST_IN_CMD;
            end else if (state_q != ST_IN_CMD) begin
               fsm_err_c = 1'b1;
            end
         end
      end
   end

   // Sticky errors (a new set beats err_clr) and saturating counters.
   always_comb begin
      overflow_d   = (overflow_q  & ~err_clr) | drop_c;
      proto_err_d  = (proto_err_q & ~err_clr) | rd_stb_c | fsm_err_c;
      cmd_count_d  = cmd_count_q;
      data_count_d = data_count_q;
      if (push_c && !q2_dc_q && (cmd_count_q != '1))
         cmd_count_d = cmd_count_q + CNT_W'(1);
      if (push_c && q2_dc_q && (data_count_q != '1))
         data_count_d = data_count_q + CNT_W'(1);
   end

   // FIFO memory has no reset; only the pointers define its contents.
   always_ff @(posedge clk) begin
      if (push_c) fifo_mem[wr_ptr_q[AW-1:0]] <= {q2_dc_q, q2_din_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1_cs_q      <= 1'b1;
         q1_e_q       <= 1'b1;
         q1_rw_q      <= 1'b0;
         q1_dc_q      <= 1'b0;
         q1_din_q     <= 8'h00;
         q2_e_q       <= 1'b1;
         q2_rw_q      <= 1'b0;
         q2_dc_q      <= 1'b0;
         q2_din_q     <= 8'h00;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rx_valid_q   <= 1'b0;
         rx_dc_q      <= 1'b0;
         rx_data_q    <= 8'h00;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         proto_err_q  <= 1'b0;
         cmd_count_q  <= '0;
         data_count_q <= '0;
         state_q      <= ST_DESEL;
         wrote_q      <= 1'b0;
      end else begin
         q1_cs_q      <= oled_cs;
         q1_e_q       <= oled_e;
         q1_rw_q      <= oled_rw;
         q1_dc_q      <= oled_dc;
         q1_din_q     <= oled_din;
         q2_e_q       <= q1_e_q;
         q2_rw_q      <= q1_rw_q;
         q2_dc_q      <= q1_dc_q;
         q2_din_q     <= q1_din_q;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rx_valid_q   <= rx_valid_d;
         rx_dc_q      <= rx_dc_d;
         rx_data_q    <= rx_data_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         proto_err_q  <= proto_err_d;
         cmd_count_q  <= cmd_count_d;
         data_count_q <= data_count_d;
         state_q      <= state_d;
         wrote_q      <= wrote_d;
      end
   end

   assign rx_valid   = rx_valid_q;
   assign rx_dc      = rx_dc_q;
   assign rx_data    = rx_data_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign proto_err  = proto_err_q;
   assign cmd_count  = cmd_count_q;
   assign data_count = data_count_q;

endmodule

// File: tb/tb_oled_bus_rx.sv
// ============================================================================
// tb_oled_bus_rx
//   Bench for oled_bus_rx (FIFO_DEPTH=4, CNT_W=4). A transaction-level model
//   tracks the byte queue, counters, sticky flags and frame state, and every
//   cycle's outputs are compared against it. Directed scenarios are followed by
//   a randomized bus phase.
// ============================================================================
module tb_oled_bus_rx;

   localparam int DEPTH = 4;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk, rst;
   logic          cs, e, rw, dc, ready, err_clr;
   logic [7:0]    din;
   logic          rx_valid, rx_dc, frame_done, overflow, proto_err;
   logic [7:0]    rx_data;
   logic [CW-1:0] cmd_count, data_count;

   oled_bus_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .oled_cs(cs), .oled_e(e), .oled_rw(rw), .oled_dc(dc), .oled_din(din),
      .rx_valid(rx_valid), .rx_ready(ready), .rx_dc(rx_dc), .rx_data(rx_data),
      .frame_done(frame_done), .overflow(overflow), .proto_err(proto_err),
      .err_clr(err_clr), .cmd_count(cmd_count), .data_count(data_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   typedef struct {
      bit cs, e, rw, dc;
      bit [7:0] din;
   } snap_t;

   snap_t    h1, h2;          // bus as seen at the previous two clock edges
   bit [8:0] mq[$];           // {dc, byte}
   int       m_cmd, m_data;
   bit       m_ovf, m_perr, m_fd;
   bit       m_sel, m_saw_cmd, m_wrote;
   bit       rand_mode;

   int n_run, n_fail;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cmd = 0; m_data = 0;
      m_ovf = 0; m_perr = 0; m_fd = 0;
      m_sel = 0; m_saw_cmd = 0; m_wrote = 0;
      h1 = '{cs: 1, e: 1, rw: 0, dc: 0, din: 8'h00};
      h2 = h1;
   endtask

   // One clock edge of the model. h0 is the bus at this edge.
   task automatic model_edge(input snap_t h0, input bit rdy, input bit clr);
      bit fell, wr, rd, pop, push, set_p, set_o;
      fell  = h2.e && !h1.e && !h1.cs;   // e seen high, then low while selected
      wr    = fell && !h2.rw;
      rd    = fell && h2.rw;
      pop   = (mq.size() > 0) && rdy;
      push  = 0;
      set_p = rd;
      set_o = 0;
      if (pop) void'(mq.pop_front());
      if (wr) begin
         if (mq.size() < DEPTH) push = 1;
         else set_o = 1;
      end
      if (push) begin
         mq.push_back({h2.dc, h2.din});
         if (!h2.dc && m_cmd < CMAX) m_cmd++;
         if (h2.dc && m_data < CMAX) m_data++;
      end
      m_fd = 0;
      if (h1.cs) begin
         m_fd      = m_sel && m_wrote;
         m_sel     = 0;
         m_wrote   = 0;
         m_saw_cmd = 0;
      end else begin
         if (!m_sel) begin
            m_sel = 1; m_saw_cmd = 0; m_wrote = 0;
         end
         if (push) begin
            m_wrote = 1;
            if (!h2.dc) m_saw_cmd = 1;
            else if (!m_saw_cmd) set_p = 1;
         end
      end
      m_perr = (m_perr && !clr) || set_p;
      m_ovf  = (m_ovf && !clr) || set_o;
      h2 = h1;
      h1 = h0;
   endtask

   task automatic compare_all();
      bit [8:0] hd;
      check_eq("rx_valid", rx_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         hd = mq[0];
         check_eq("rx_dc", rx_dc, hd[8]);
         check_eq("rx_data", rx_data, hd[7:0]);
      end
      check_eq("frame_done", frame_done, m_fd);
      check_eq("overflow", overflow, m_ovf);
      check_eq("proto_err", proto_err, m_perr);
      check_eq("cmd_count", cmd_count, m_cmd);
      check_eq("data_count", data_count, m_data);
   endtask

   // One clock: inputs already set, edge, model update, compare 1 time unit later.
   task automatic step();
      snap_t h0;
      if (rand_mode) begin
         ready   = 1'($urandom_range(0, 1));
         err_clr = ($urandom_range(0, 19) == 0);
      end
      h0 = '{cs: cs, e: e, rw: rw, dc: dc, din: din};
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge(h0, ready, err_clr);
      #1;
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic bus_wr(input bit d, input bit [7:0] v);
      rw = 0; dc = d; din = v; e = 1;
      step();
      e = 0;
      step();
   endtask

   task automatic bus_rd();
      rw = 1; e = 1;
      step();
      e = 0;
      step();
      rw = 0;
   endtask

   // Drain with ready held high; returns how many cycles the DUT offered a head.
   task automatic drain(output int offered);
      offered = 0;
      ready = 1;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         if (rx_valid) offered++;
         step();
      end
      ready = 0;
   endtask

   int n, fd_cnt, r;

   initial begin
      n_run = 0; n_fail = 0; rand_mode = 0;
      rst = 1; cs = 1; e = 0; rw = 0; dc = 0; din = 8'h00; ready = 0; err_clr = 0;
      model_reset();
      step();
      check_eq("reset_rx_valid", rx_valid, 0);
      check_eq("reset_rx_data", rx_data, 0);
      check_eq("reset_cmd_count", cmd_count, 0);
      rst = 0;
      steps(3);

      // Test 1: command + parameter, then deselect
      cs = 0; steps(2);
      bus_wr(0, 8'h81);
      check_eq("t1_head_data", rx_data, 8'h00);   // push lands one cycle after e falls
      step();
      check_eq("t1_head_valid", rx_valid, 1);
      check_eq("t1_head_cmd", rx_data, 8'h81);
      bus_wr(1, 8'h7F);
      steps(2);
      cs = 1;
      fd_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (frame_done) fd_cnt++;
      end
      check_eq("t1_frame_done_pulses", fd_cnt, 1);
      check_eq("t1_cmd_count", cmd_count, 1);
      check_eq("t1_data_count", data_count, 1);
      check_eq("t1_no_err", {overflow, proto_err}, 0);
      drain(n);
      check_eq("t1_entries", n, 2);

      // Test 2: overfill with the consumer stalled
      cs = 0; steps(2);
      for (int i = 0; i < 6; i++) bus_wr(i != 0, 8'(8'h10 + i));
      steps(2);
      check_eq("t2_overflow", overflow, 1);
      check_eq("t2_cmd_count", cmd_count, 2);
      check_eq("t2_data_count", data_count, 4);
      drain(n);
      check_eq("t2_entries", n, 4);
      err_clr = 1; step(); err_clr = 0;
      check_eq("t2_overflow_clr", overflow, 0);
      cs = 1; steps(3);

      // Test 3: data byte before any command
      cs = 0; steps(2);
      bus_wr(1, 8'hA5);
      step();
      check_eq("t3_proto_err", proto_err, 1);
      check_eq("t3_head_dc", rx_dc, 1);
      check_eq("t3_head_data", rx_data, 8'hA5);
      err_clr = 1; step(); err_clr = 0;
      check_eq("t3_proto_err_clr", proto_err, 0);
      drain(n);

      // Test 4: read cycle is rejected
      bus_rd();
      step();
      check_eq("t4_proto_err", proto_err, 1);
      check_eq("t4_no_push", rx_valid, 0);
      check_eq("t4_cmd_count", cmd_count, 2);
      check_eq("t4_data_count", data_count, 5);
      err_clr = 1; step(); err_clr = 0;
      cs = 1; steps(3);

      // Test 5: push and pop on a full FIFO in the same cycle
      cs = 0; steps(2);
      for (int i = 0; i < 4; i++) bus_wr(i != 0, 8'(8'h20 + i));
      bus_wr(1, 8'h24);
      ready = 1; step(); ready = 0;
      steps(2);
      check_eq("t5_overflow", overflow, 0);
      check_eq("t5_head_data", rx_data, 8'h21);
      drain(n);
      check_eq("t5_occupancy", n, 4);
      cs = 1; steps(3);

      // Test 6: asynchronous reset mid-transfer
      cs = 0; steps(2);
      for (int i = 0; i < 3; i++) bus_wr(i != 0, 8'(8'h30 + i));
      din = 8'h3F; dc = 1; e = 1;
      step();
      #2 rst = 1;
      #1;
      check_eq("t6_async_rx_valid", rx_valid, 0);
      check_eq("t6_async_counts", {cmd_count, data_count}, 0);
      model_reset();
      step();
      rst = 0; e = 0; cs = 1;
      steps(3);
      cs = 0; steps(2);
      bus_wr(0, 8'h42);
      step();
      check_eq("t6_sole_entry", rx_data, 8'h42);
      drain(n);
      check_eq("t6_entries", n, 1);
      cs = 1; steps(3);

      // Randomized bus traffic
      rand_mode = 1;
      for (int k = 0; k < 500; k++) begin
         r = $urandom_range(0, 99);
         if (r < 55) begin
            bus_wr(1'($urandom_range(0, 2) != 0), 8'($urandom));
         end else if (r < 63) begin
            bus_rd();
         end else if (r < 75) begin
            cs = ~cs;
            step();
         end else if (r < 82) begin
            e = 1; rw = 0; din = 8'($urandom);
            step();
            e = 0; cs = 1;   // e falls as cs rises: must be ignored
            step();
         end else begin
            step();
         end
      end
      rand_mode = 0; ready = 0; err_clr = 0;
      steps(2);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
